// File: rtl/conv_operand_buffer.sv
// Operand buffer for the convolution datapath: loads an N x N matrix or a K x K filter
// as a serial element stream and publishes it, zero-padded and row-major, on a flat bus.
module conv_operand_buffer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAT_DIM = 4,
  parameter int unsigned FLT_DIM = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                mode,
  input  logic                                abort,
  input  logic                                in_valid,
  input  logic [DATA_W-1:0]                   in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_mode,
  output logic [MAT_DIM*MAT_DIM*DATA_W-1:0]   out_data,
  output logic                                busy
);

  localparam int unsigned NN    = MAT_DIM * MAT_DIM;
  localparam int unsigned KK    = FLT_DIM * FLT_DIM;
  localparam int unsigned CNT_W = $clog2(NN + 1);
  localparam int unsigned BUF_W = NN * DATA_W;
  localparam logic [CNT_W-1:0] LAST_MAT = CNT_W'(NN - 1);
  localparam logic [CNT_W-1:0] LAST_FLT = CNT_W'(KK - 1);

  if (FLT_DIM > MAT_DIM) begin : g_bad_cfg
    $error("conv_operand_buffer: FLT_DIM must not exceed MAT_DIM");
  end

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [BUF_W-1:0]   shadow_q, shadow_d;
  logic [BUF_W-1:0]   out_data_q, out_data_d;
  logic               out_mode_q, out_mode_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic               last;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    out_valid_d = out_valid_q;
    accept      = 1'b0;
    last        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          shadow_d = '0;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        accept = in_valid & in_ready_q;
        last   = (cnt_q == (mode_q ? LAST_MAT : LAST_FLT));
        // abort wins over a coincident final handshake: nothing is published
        if (abort) begin
          shadow_d = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (accept) begin
          for (int unsigned i = 0; i < NN; i++) begin
            if (cnt_q == CNT_W'(i)) shadow_d[i*DATA_W +: DATA_W] = in_data;
          end
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            out_data_d  = shadow_d;
            out_mode_d  = mode_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_operand_buffer.sv
// Scoreboard bench for conv_operand_buffer: directed loads push expected operands,
// a monitor pops and compares on every out_valid rise.
module tb_conv_operand_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, mode, abort, in_valid, out_ready;
  logic [7:0]   in_data;
  logic         in_ready, out_valid, out_mode, busy;
  logic [127:0] out_data;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  int unsigned  cyc      = 0;
  logic [128:0] sb[$];
  logic         prev_v   = 1'b0;

  conv_operand_buffer #(.DATA_W(8), .MAT_DIM(4), .FLT_DIM(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] seq(input int unsigned base, input int unsigned cnt);
    logic [127:0] r = '0;
    for (int unsigned i = 0; i < 16; i++)
      if (i < cnt) r[i*8 +: 8] = 8'(base + i);
    return r;
  endfunction

  // Monitor: every new publish must match the oldest expected operand
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_publish: got data %h with no expected entry", out_data);
      end else begin
        logic [128:0] e;
        e = sb.pop_front();
        check("publish_data", {1'b0, out_data}, {1'b0, e[127:0]});
        check("publish_mode", {128'b0, out_mode}, {128'b0, e[128]});
      end
    end
    prev_v = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int unsigned t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      check("in_ready_wait", {128'b0, in_ready}, 129'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_load(input logic m, input logic [127:0] exp, input bit push);
    start = 1'b1;
    mode  = m;
    if (push) sb.push_back({m, exp});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int unsigned t = 0;
    while (!out_valid && t < 50) begin
      tick();
      t++;
    end
    check("out_valid_wait", {128'b0, out_valid}, 129'd1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ack_valid_low", {128'b0, out_valid}, 129'd0);
    check("ack_busy_low", {128'b0, busy}, 129'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] mat1, flt_a, flt_11, mat40, mat50;
    int unsigned  s;
    mat1   = seq(1, 16);
    flt_a  = seq('hA0, 9);
    flt_11 = seq('h11, 9);
    mat40  = seq('h40, 16);
    mat50  = seq('h50, 16);
    rst = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    #12;
    check("rst_out_valid", {128'b0, out_valid}, 129'd0);
    check("rst_in_ready", {128'b0, in_ready}, 129'd0);
    check("rst_busy", {128'b0, busy}, 129'd0);
    check("rst_out_mode", {128'b0, out_mode}, 129'd0);
    check("rst_out_data", {1'b0, out_data}, 129'd0);
    tick();
    rst = 1'b1;
    tick();

    // Matrix 1..16 back-to-back, latency measured from the start edge
    s = cyc;
    begin_load(1'b1, mat1, 1'b1);
    check("first_in_ready", {128'b0, in_ready}, 129'd1);
    for (int unsigned i = 0; i < 16; i++) send(8'(i + 1));
    check("in_ready_after_last", {128'b0, in_ready}, 129'd0);
    wait_valid();
    check("matrix_latency", 129'(cyc - s), 129'd17);

    // Backpressure: published operand stays put; start in HOLD ignored
    for (int unsigned i = 0; i < 20; i++) begin
      if (i == 10) begin start = 1'b1; mode = 1'b0; end
      tick();
      start = 1'b0;
      check("hold_valid", {128'b0, out_valid}, 129'd1);
      check("hold_data", {1'b0, out_data}, {1'b0, mat1});
      if (i == 10) begin
        check("hold_start_busy", {128'b0, busy}, 129'd1);
        check("hold_start_in_ready", {128'b0, in_ready}, 129'd0);
      end
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("ack_valid_low", {128'b0, out_valid}, 129'd0);
    tick();
    check("start_with_ack_dropped", {128'b0, in_ready}, 129'd0);
    check("start_with_ack_busy", {128'b0, busy}, 129'd0);

    // Double buffer: old matrix visible while the filter loads
    begin_load(1'b0, flt_a, 1'b1);
    for (int unsigned i = 0; i < 9; i++) begin
      send(8'('hA0 + i));
      if (i < 8) check("dbuf_hold", {1'b0, out_data}, {1'b0, mat1});
    end
    wait_valid();
    ack();

    // Filter with gapped input, zero padding above element 8
    begin_load(1'b0, flt_11, 1'b1);
    for (int unsigned i = 0; i < 9; i++) begin
      send(8'('h11 + i));
      if (i < 8) tick();
    end
    wait_valid();
    check("filter_pad", {1'b0, out_data}, {1'b0, flt_11});
    ack();

    // Abort coincident with the final handshake: nothing published
    begin_load(1'b1, '0, 1'b0);
    for (int unsigned i = 0; i < 15; i++) send(8'('h30 + i));
    in_valid = 1'b1;
    in_data  = 8'h3F;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    check("abort_valid", {128'b0, out_valid}, 129'd0);
    check("abort_busy", {128'b0, busy}, 129'd0);
    check("abort_in_ready", {128'b0, in_ready}, 129'd0);
    check("abort_data_kept", {1'b0, out_data}, {1'b0, flt_11});
    for (int unsigned i = 0; i < 3; i++) tick();
    check("abort_no_publish", {128'b0, out_valid}, 129'd0);
    begin_load(1'b1, mat40, 1'b1);
    for (int unsigned i = 0; i < 16; i++) send(8'('h40 + i));
    wait_valid();
    ack();

    // Asynchronous reset in the middle of a matrix load
    begin_load(1'b1, '0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) send(8'('h60 + i));
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {128'b0, out_valid}, 129'd0);
    check("midrst_in_ready", {128'b0, in_ready}, 129'd0);
    check("midrst_busy", {128'b0, busy}, 129'd0);
    check("midrst_out_data", {1'b0, out_data}, 129'd0);
    tick();
    rst = 1'b1;
    tick();
    begin_load(1'b1, mat50, 1'b1);
    for (int unsigned i = 0; i < 16; i++) send(8'('h50 + i));
    wait_valid();
    ack();

    tick();
    tick();
    check("scoreboard_empty", 129'(sb.size()), 129'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_operand_buffer.md
Name: conv_operand_buffer

Overview:
Parametrised successor of the operand memory that feeds the convolution datapath. Loads either an N x N input matrix or a K x K filter as a serial element stream over a valid/ready handshake, instead of one wide parallel word. Assembles the elements in a shadow buffer and publishes the completed, zero-padded, row-major operand on a flat output bus with its own valid/ready handshake. Double buffering keeps the published operand stable while the next one loads.

Parameters:
DATA_W, 8, bit width of one element
MAT_DIM, 4, matrix side N; matrix mode loads N*N elements
FLT_DIM, 3, filter side K (K <= N); filter mode loads K*K elements

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a load; sampled only in IDLE
mode  in  1  sampled with start: 0 = filter (K*K), 1 = matrix (N*N)
abort  in  1  synchronous cancel of an in-progress load
in_valid  in  1  element available on in_data
in_data  in  DATA_W  element, row-major order
in_ready  out  1  buffer accepts an element this cycle
out_valid  out  1  published operand is complete and valid
out_ready  in  1  consumer takes the published operand
out_mode  out  1  mode of the published operand
out_data  out  N*N*DATA_W  flat operand; element i at [i*DATA_W +: DATA_W]
busy  out  1  high in LOAD and HOLD

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; element counter = 0; shadow buffer = 0; out_data = 0.
  - in_ready = 0, out_valid = 0, out_mode = 0, busy = 0.
- States: IDLE, LOAD, HOLD.
- IDLE:
  - start = 1: latch mode, clear the shadow buffer and counter, go to LOAD the next cycle. Without start, stay in IDLE.
- LOAD:
  - in_ready = 1 (registered, asserted from the first LOAD cycle).
  - Each cycle with in_valid & in_ready: shadow[cnt] <= in_data, then cnt++.
  - Target count T = K*K (filter) or N*N (matrix).
  - On the handshake with cnt == T-1 (last element), in the same edge:
    - copy the shadow buffer to out_data;
    - out_mode <= latched mode;
    - out_valid <= 1;
    - go to HOLD.
  - in_ready deasserts in that same edge, so no element is accepted beyond T.
  - Filter mode: out_data elements K*K .. N*N-1 are 0. Filter element i sits at flat index i, packed row-major (K*K contiguous), not placed into the N x N grid.
  - start is ignored in LOAD.
  - in_valid low stalls with no timeout; the counter holds.
- HOLD:
  - out_valid = 1; out_data and out_mode are stable.
  - out_ready = 1: out_valid <= 0, go to IDLE. A new start is accepted in the following IDLE cycle at the earliest.
  - out_ready is not sampled outside HOLD.
  - start in HOLD, including in the same cycle as out_ready, is ignored; it is not queued.
- abort:
  - In LOAD: go to IDLE, zero the shadow buffer and counter, drop in_ready. out_data/out_mode/out_valid keep their previous values (out_valid is already 0).
  - abort has priority over a simultaneous final-element handshake: the element is dropped and nothing is published.
  - In IDLE and HOLD, abort has no effect.
- Stability:
  - out_data changes only on the final-element edge or on reset. It is not cleared on out_ready, so the last operand stays readable while the next one loads.
- Latency:
  - start to first in_ready: 1 cycle.
  - Last element handshake to out_valid: 1 cycle (registered).
  - With back-to-back input, start to out_valid is T+1 cycles.
- Elaboration:
  - FLT_DIM > MAT_DIM is an illegal configuration.
  - Counter width is clog2(N*N + 1).

Test Plan:
- Reset mid-LOAD after 5 of 16 matrix elements: drop rst -> out_valid = 0, in_ready = 0, busy = 0, out_data = 0 immediately; restart loads cleanly.
- Matrix load: start with mode = 1, stream elements 1..16 back-to-back -> out_valid rises exactly 17 cycles after start; out_data element i = i+1; out_mode = 1; in_ready low after the 16th element.
- Filter load: mode = 0, stream 0x11..0x19 with in_valid gapped every other cycle -> out_data elements 0..8 = 0x11..0x19, elements 9..15 = 0; out_mode = 0.
- Backpressure/stability: hold out_ready = 0 for 20 cycles -> out_valid and out_data remain constant; a start pulsed during HOLD is ignored (busy stays, no in_ready); out_ready = 1 -> out_valid = 0 next cycle.
- Double buffer: after publishing the matrix 1..16 and acking, load the filter 0xA0..0xA8 -> out_data stays 1..16 throughout the load and switches to the filter on the final edge.
- Abort: start a matrix, send 15 elements, then assert abort together with the 16th handshake -> no out_valid; previous out_data unchanged; state IDLE; the next full load publishes correctly.
